display_spi_stream: RTL and testbench
=====================================

Name: display_spi_stream

Overview:
- Parametrised successor to the single-byte SSD1306 SPI link.
- Accepts reset, command and data requests through a valid/ready queue of configurable depth, and serialises them onto a 4-wire SPI display bus (mode 0, MSB first).
- Holds CS low across consecutive same-kind bytes, so a frame refresh streams as one burst.
- Sits between the display controller FSM and the OLED pins.

Parameters:
- CLK_DIV, 11: clk cycles per SPI half-period; must be ≥1.
- FIFO_DEPTH, 4: request queue entries; power of two, ≥2.
- RST_HALF_PERIODS, 2: half-periods that spi_rst is held low, then the same number held high before the next request.
- CS_GAP, 1: half-periods that CS stays high after a burst ends.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when req_valid is also high; equals !fifo_full
- req_kind  in  2  0=NONE, 1=RESET, 2=COMMAND, 3=DATA
- req_byte  in  8  byte to send; ignored for RESET
- busy  out  1  queue non-empty or engine not IDLE
- fifo_level  out  $clog2(FIFO_DEPTH)+1  queued entries
- spi_din, spi_clk, spi_cs, spi_dc, spi_rst  out  1 each  display pins

Behaviour:
- Reset values (cycle after rst=1): spi_clk=0, spi_cs=1, spi_rst=1, spi_dc=0, spi_din=0, queue empty, engine in IDLE, divider=0, busy=0.
- A reset asserted mid-byte or mid-display-reset aborts the operation; CS is high on the next cycle.
- req_valid during rst is dropped.
- Queue:
  - Push when req_valid && req_ready. Entry is {kind, byte}.
  - kind NONE is acknowledged (ready as usual) but not stored.
  - When full, req_ready=0 even if a pop occurs in the same cycle (no pass-through).
  - Push and pop in the same cycle when neither full nor empty leaves fifo_level unchanged.
  - Ordering is strict FIFO; RESET entries are ordered with bytes.
- Tick: the divider counts 0..CLK_DIV-1 and produces a one-cycle tick when it wraps. The divider is cleared on every state entry.
- Engine FSM states: IDLE, RST_LO, RST_HI, SHIFT, GAP.
- IDLE, queue non-empty: pop the head in that cycle.
  - RESET: spi_rst<=0, go to RST_LO.
  - COMMAND/DATA: spi_cs<=0, spi_dc<=(kind==DATA), spi_din<=byte[7], bitcnt<=7, go to SHIFT.
- RST_LO: after RST_HALF_PERIODS ticks, spi_rst<=1 and go to RST_HI. RST_HI: after RST_HALF_PERIODS ticks, go to IDLE. CS stays high throughout.
- SHIFT: on each tick spi_clk toggles.
  - Rising edge (0->1): the display samples din.
  - Falling edge (1->0) with bitcnt>0: shift out the next bit, decrement bitcnt.
  - Falling edge with bitcnt==0: the byte is done, at exactly 16 ticks after entry.
- Byte done:
  - If the queue head is COMMAND/DATA with the same dc value, pop it, load its bit7 on the same cycle, and stay in SHIFT with CS low (burst).
  - Otherwise spi_cs<=1 and go to GAP.
- GAP: after CS_GAP ticks, go to IDLE.
- spi_clk is 0 in every state except SHIFT, and SPI clock edges only occur in SHIFT.
- dc changes only while CS is high or at a byte boundary with spi_clk=0.
- Throughput: a burst of N bytes takes N*16*CLK_DIV clk cycles of CS low, with no idle half-periods between bytes.
- busy drops the cycle after the engine returns to IDLE with the queue empty.

Decomposition:
- Shared package display_pkg: REQ_NONE/RESET/COMMAND/DATA 2-bit constants, engine state encodings, and the SSD1306 opcode constants already used by the display controller.
- One sub-module, display_req_fifo: synchronous FIFO of width 10 and depth FIFO_DEPTH, with level output and synchronous reset. The engine and tick divider live in the top module.

Test Plan:
- CLK_DIV=2, push COMMAND 0xAE.
  - Required: CS low for 32 clk cycles, dc=0.
  - din sampled on the 8 rising edges reads 1,0,1,0,1,1,1,0.
  - CS high for ≥2 cycles (GAP), then busy=0.
- Push DATA 0x55, 0xAA, 0xFF back-to-back.
  - Required: a single CS-low window of 96 cycles, dc=1 throughout.
  - 24 rising edges decode to 0x55, 0xAA, 0xFF.
- Push COMMAND 0x21 then DATA 0x01.
  - Required: CS rises between the two bytes, dc changes 0->1 only while CS=1, giving two separate CS windows.
- Push RESET then COMMAND 0xAF (RST_HALF_PERIODS=2, CLK_DIV=2).
  - Required: spi_rst low for exactly 4 cycles, then high for 4 cycles before CS falls; no spi_clk edges during reset.
- Fill FIFO_DEPTH=4 while the engine is shifting.
  - Required: req_ready=0 at level 4 and returns to 1 the cycle after a pop.
  - A NONE push does not change fifo_level.
- Assert rst during bit 3 of a byte.
  - Required: the next cycle shows spi_cs=1, spi_clk=0, fifo_level=0, busy=0.
  - A following push of 0x3C transmits cleanly.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the SSD1306 display path: request kinds, engine states
// and the controller's opcode constants.
package display_pkg;

    localparam logic [1:0] REQ_NONE    = 2'd0;
    localparam logic [1:0] REQ_RESET   = 2'd1;
    localparam logic [1:0] REQ_COMMAND = 2'd2;
    localparam logic [1:0] REQ_DATA    = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RST_LO = 3'd1,
        ST_RST_HI = 3'd2,
        ST_SHIFT  = 3'd3,
        ST_GAP    = 3'd4
    } engine_state_t;

    localparam logic [7:0] OP_DISPLAY_OFF    = 8'hAE;
    localparam logic [7:0] OP_DISPLAY_ON     = 8'hAF;
    localparam logic [7:0] OP_SET_COL_ADDR   = 8'h21;
    localparam logic [7:0] OP_SET_PAGE_ADDR  = 8'h22;
    localparam logic [7:0] OP_CHARGE_PUMP    = 8'h8D;
    localparam logic [7:0] OP_SET_CONTRAST   = 8'h81;

    function automatic logic is_byte_kind(input logic [1:0] kind);
        return (kind == REQ_COMMAND) || (kind == REQ_DATA);
    endfunction

endpackage

// File: rtl/display_req_fifo.sv
// Synchronous request queue with occupancy output; a push while full is ignored,
// so a pop in the same cycle never lets a new entry slip through.
module display_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/display_spi_stream.sv
// Queued SSD1306 link: serialises reset pulses and command/data bytes onto a
// 4-wire SPI bus (mode 0, MSB first), keeping CS low across same-kind bytes.
module display_spi_stream
    import display_pkg::*;
#(
    parameter int CLK_DIV          = 11,
    parameter int FIFO_DEPTH       = 4,
    parameter int RST_HALF_PERIODS = 2,
    parameter int CS_GAP           = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [1:0]                    req_kind,
    input  logic [7:0]                    req_byte,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          spi_din,
    output logic                          spi_clk,
    output logic                          spi_cs,
    output logic                          spi_dc,
    output logic                          spi_rst
);

    localparam int DIV_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DIV_LAST_I  = CLK_DIV - 1;
    localparam int RST_LAST_I  = RST_HALF_PERIODS - 1;
    localparam int GAP_LAST_I  = CS_GAP - 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_LAST_I[DIV_W-1:0];
    localparam logic [15:0]      RST_LAST = RST_LAST_I[15:0];
    localparam logic [15:0]      GAP_LAST = GAP_LAST_I[15:0];

    engine_state_t     state, state_next;
    logic [DIV_W-1:0]  div_cnt, div_next;
    logic [15:0]       tick_cnt, tick_cnt_next;
    logic [2:0]        bit_cnt, bit_cnt_next;
    logic [7:0]        shreg, shreg_next;
    logic              sclk_next, cs_next, dc_next, din_next, rst_pin_next;
    logic              tick;
    logic              push, pop, full, empty;
    logic [9:0]        head;
    logic [1:0]        head_kind;
    logic [7:0]        head_byte;

    assign req_ready = !full;
    assign push      = req_valid && req_ready && (req_kind != REQ_NONE);
    assign head_kind = head[9:8];
    assign head_byte = head[7:0];
    assign tick      = (div_cnt == DIV_LAST);
    assign busy      = !empty || (state != ST_IDLE);

    display_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (10)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({req_kind, req_byte}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_comb begin
        state_next    = state;
        div_next      = div_cnt;
        tick_cnt_next = tick_cnt;
        bit_cnt_next  = bit_cnt;
        shreg_next    = shreg;
        sclk_next     = spi_clk;
        cs_next       = spi_cs;
        dc_next       = spi_dc;
        din_next      = spi_din;
        rst_pin_next  = spi_rst;
        pop           = 1'b0;

        if (state != ST_IDLE) div_next = tick ? '0 : div_cnt + 1'b1;

        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head_kind == REQ_RESET) begin
                        rst_pin_next = 1'b0;
                        state_next   = ST_RST_LO;
                    end else begin
                        cs_next      = 1'b0;
                        dc_next      = (head_kind == REQ_DATA);
                        din_next     = head_byte[7];
                        shreg_next   = head_byte;
                        bit_cnt_next = 3'd7;
                        state_next   = ST_SHIFT;
                    end
                end
            end
            ST_RST_LO: begin
                if (tick) begin
                    if (tick_cnt == RST_LAST) begin
                        rst_pin_next = 1'b1;
                        state_next   = ST_RST_HI;
                    end else begin
                        tick_cnt_next = tick_cnt + 16'd1;
                    end
                end
            end
            ST_RST_HI: begin
                if (tick) begin
                    if (tick_cnt == RST_LAST) state_next = ST_IDLE;
                    else                      tick_cnt_next = tick_cnt + 16'd1;
                end
            end
            ST_SHIFT: begin
                // Data changes only on falling edges; the byte boundary is the
                // falling edge after bit 0, where a same-dc head extends the burst.
                if (tick) begin
                    sclk_next = ~spi_clk;
                    if (spi_clk) begin
                        if (bit_cnt != 3'd0) begin
                            din_next     = shreg[6];
                            shreg_next   = {shreg[6:0], 1'b0};
                            bit_cnt_next = bit_cnt - 3'd1;
                        end else if (!empty && is_byte_kind(head_kind) &&
                                     ((head_kind == REQ_DATA) == spi_dc)) begin
                            pop          = 1'b1;
                            din_next     = head_byte[7];
                            shreg_next   = head_byte;
                            bit_cnt_next = 3'd7;
                        end else begin
                            cs_next    = 1'b1;
                            state_next = ST_GAP;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (tick_cnt == GAP_LAST) state_next = ST_IDLE;
                    else                      tick_cnt_next = tick_cnt + 16'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (state_next != state) begin
            div_next      = '0;
            tick_cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            div_cnt  <= '0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            spi_clk  <= 1'b0;
            spi_cs   <= 1'b1;
            spi_dc   <= 1'b0;
            spi_din  <= 1'b0;
            spi_rst  <= 1'b1;
        end else begin
            state    <= state_next;
            div_cnt  <= div_next;
            tick_cnt <= tick_cnt_next;
            bit_cnt  <= bit_cnt_next;
            shreg    <= shreg_next;
            spi_clk  <= sclk_next;
            spi_cs   <= cs_next;
            spi_dc   <= dc_next;
            spi_din  <= din_next;
            spi_rst  <= rst_pin_next;
        end
    end

endmodule

// File: tb/tb_display_spi_stream.sv
// Scoreboard bench: accepted requests form the expected stream; a pin-level
// monitor decodes SPI bytes and reset pulses and checks bus protocol rules.
module tb_display_spi_stream;
    import display_pkg::*;

    localparam int CLK_DIV     = 2;
    localparam int FIFO_DEPTH  = 4;
    localparam int RST_HP      = 2;
    localparam int CS_GAP      = 1;
    localparam int BYTE_CYCLES = 16 * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_kind;
    logic [7:0] req_byte;
    logic       busy;
    logic [2:0] fifo_level;
    logic       spi_din, spi_clk, spi_cs, spi_dc, spi_rst;

    always #5 clk = ~clk;

    display_spi_stream #(
        .CLK_DIV          (CLK_DIV),
        .FIFO_DEPTH       (FIFO_DEPTH),
        .RST_HALF_PERIODS (RST_HP),
        .CS_GAP           (CS_GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_kind   (req_kind),
        .req_byte   (req_byte),
        .busy       (busy),
        .fifo_level (fifo_level),
        .spi_din    (spi_din),
        .spi_clk    (spi_clk),
        .spi_cs     (spi_cs),
        .spi_dc     (spi_dc),
        .spi_rst    (spi_rst)
    );

    int         tests_run = 0;
    int         tests_failed = 0;
    logic [9:0] exp_q[$];
    int         win_len[$];
    int         win_bytes[$];
    int         proto_err = 0;

    logic       prev_sclk = 1'b0, prev_cs = 1'b1, prev_dc = 1'b0, prev_rstpin = 1'b1;
    int         bit_n = 0;
    logic [7:0] shift_byte = 8'h00;
    int         cs_low_len = 0, bytes_in_win = 0;
    int         rst_low_len = 0, last_rst_low = 0;
    int         rst_gap = 0, last_rst_gap = 0;
    bit         rst_gap_on = 1'b0;
    int         gap_cnt = 0, last_gap = 0;
    bit         gap_on = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkAtLeast(input string name, input int actual, input int minimum);
        tests_run++;
        if (actual < minimum) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected at least %0d", name, actual, minimum);
        end
    endtask

    task automatic scoreboardCheck(input string name, input logic [9:0] got);
        if (exp_q.size() == 0) checkOutput({name, "_unexpected"}, 32'(got), 32'hFFFF_FFFF);
        else                   checkOutput(name, 32'(got), 32'(exp_q.pop_front()));
    endtask

    // Pin monitor: decodes rising-edge samples into bytes and tracks CS windows,
    // reset pulses and the idle time that follows a burst.
    always @(negedge clk) begin
        if (rst) begin
            bit_n = 0;
            cs_low_len = 0;
            bytes_in_win = 0;
            rst_low_len = 0;
            rst_gap_on = 1'b0;
            gap_on = 1'b0;
        end else begin
            if (spi_clk && spi_cs) proto_err++;
            if ((spi_dc != prev_dc) && !spi_cs && !prev_cs) proto_err++;
            if (!spi_cs) cs_low_len++;
            if (!prev_sclk && spi_clk && !spi_cs) begin
                shift_byte = {shift_byte[6:0], spi_din};
                bit_n++;
                if (bit_n == 8) begin
                    bit_n = 0;
                    bytes_in_win++;
                    scoreboardCheck("spi_byte", {(spi_dc ? REQ_DATA : REQ_COMMAND), shift_byte});
                end
            end
            if (!prev_cs && spi_cs) begin
                if (bit_n != 0) proto_err++;
                win_len.push_back(cs_low_len);
                win_bytes.push_back(bytes_in_win);
                cs_low_len = 0;
                bytes_in_win = 0;
                gap_cnt = 0;
                gap_on = 1'b1;
            end
            if (gap_on) begin
                if (busy && spi_cs) gap_cnt++;
                else begin
                    last_gap = gap_cnt;
                    gap_on = 1'b0;
                end
            end
            if (!spi_rst) rst_low_len++;
            if (!prev_rstpin && spi_rst) begin
                last_rst_low = rst_low_len;
                rst_low_len = 0;
                rst_gap = 0;
                rst_gap_on = 1'b1;
                scoreboardCheck("spi_reset", {REQ_RESET, 8'h00});
            end
            if (rst_gap_on) begin
                if (spi_cs && spi_rst) rst_gap++;
                else begin
                    last_rst_gap = rst_gap;
                    rst_gap_on = 1'b0;
                end
            end
        end
        prev_sclk   = spi_clk;
        prev_cs     = spi_cs;
        prev_dc     = spi_dc;
        prev_rstpin = spi_rst;
    end

    task automatic applyStimulus(input logic [1:0] kind, input logic [7:0] data);
        int guard = 0;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_kind  = kind;
        req_byte  = data;
        @(negedge clk);
        while (!req_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            checkOutput("push_timeout", 32'(req_ready), 32'd1);
        end else begin
            @(posedge clk);
            if (kind != REQ_NONE) exp_q.push_back({kind, (kind == REQ_RESET) ? 8'h00 : data});
        end
        #1 req_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int guard = 0;
        @(negedge clk);
        while (busy && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (busy) checkOutput("idle_timeout", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic clearWindows();
        win_len.delete();
        win_bytes.delete();
        proto_err = 0;
    endtask

    task automatic checkBurst(input string name, input int windows, input int bytes_first);
        checkOutput({name, "_windows"}, 32'(win_len.size()), 32'(windows));
        if (win_len.size() >= 1) begin
            checkOutput({name, "_cs_low_cycles"}, 32'(win_len[0]), 32'(bytes_first * BYTE_CYCLES));
            checkOutput({name, "_bytes_in_window"}, 32'(win_bytes[0]), 32'(bytes_first));
        end
        checkOutput({name, "_protocol_errors"}, 32'(proto_err), 32'd0);
        checkOutput({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int guard;
        logic [1:0] rkind;

        rst = 1'b1;
        req_valid = 1'b0;
        req_kind = REQ_NONE;
        req_byte = 8'h00;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_spi_clk", 32'(spi_clk), 32'd0);
        checkOutput("rst_spi_cs", 32'(spi_cs), 32'd1);
        checkOutput("rst_spi_rst", 32'(spi_rst), 32'd1);
        checkOutput("rst_spi_dc", 32'(spi_dc), 32'd0);
        checkOutput("rst_spi_din", 32'(spi_din), 32'd0);
        checkOutput("rst_fifo_level", 32'(fifo_level), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        clearWindows();
        applyStimulus(REQ_COMMAND, OP_DISPLAY_OFF);
        waitIdle();
        checkBurst("cmd_ae", 1, 1);
        checkAtLeast("cmd_ae_gap_cycles", last_gap, 2);

        clearWindows();
        applyStimulus(REQ_DATA, 8'h55);
        applyStimulus(REQ_DATA, 8'hAA);
        applyStimulus(REQ_DATA, 8'hFF);
        waitIdle();
        checkBurst("data_burst3", 1, 3);

        clearWindows();
        applyStimulus(REQ_COMMAND, OP_SET_COL_ADDR);
        applyStimulus(REQ_DATA, 8'h01);
        waitIdle();
        checkBurst("cmd_then_data", 2, 1);
        if (win_len.size() >= 2) checkOutput("cmd_then_data_second_len", 32'(win_len[1]), 32'(BYTE_CYCLES));

        clearWindows();
        applyStimulus(REQ_RESET, 8'h00);
        applyStimulus(REQ_COMMAND, OP_DISPLAY_ON);
        waitIdle();
        checkBurst("reset_then_cmd", 1, 1);
        checkOutput("reset_low_cycles", 32'(last_rst_low), 32'(RST_HP * CLK_DIV));
        checkAtLeast("reset_high_before_cs", last_rst_gap, RST_HP * CLK_DIV);

        clearWindows();
        for (int i = 0; i < 5; i++) applyStimulus(REQ_DATA, 8'($urandom));
        @(negedge clk);
        checkOutput("fill_level_full", 32'(fifo_level), 32'd4);
        checkOutput("fill_ready_low", 32'(req_ready), 32'd0);
        guard = 0;
        while (fifo_level == 3'd4 && guard < 2 * BYTE_CYCLES) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("fill_level_after_pop", 32'(fifo_level), 32'd3);
        checkOutput("fill_ready_after_pop", 32'(req_ready), 32'd1);
        applyStimulus(REQ_NONE, 8'h99);
        @(negedge clk);
        checkOutput("fill_none_level", 32'(fifo_level), 32'd3);
        waitIdle();
        checkBurst("fill_burst5", 1, 5);

        clearWindows();
        for (int i = 0; i < 24; i++) begin
            rkind = 2'($urandom_range(0, 3));
            applyStimulus(rkind, 8'($urandom));
            repeat ($urandom_range(0, 40)) @(posedge clk);
        end
        waitIdle();
        checkOutput("random_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("random_protocol_errors", 32'(proto_err), 32'd0);

        clearWindows();
        applyStimulus(REQ_COMMAND, 8'hC3);
        guard = 0;
        while (bit_n < 4 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("abort_reached_bit3", 32'(bit_n), 32'd4);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = 1'b1;
        req_kind = REQ_DATA;
        req_byte = 8'h77;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_spi_cs", 32'(spi_cs), 32'd1);
        checkOutput("abort_spi_clk", 32'(spi_clk), 32'd0);
        checkOutput("abort_fifo_level", 32'(fifo_level), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("abort_dropped_level", 32'(fifo_level), 32'd0);
        checkOutput("abort_dropped_busy", 32'(busy), 32'd0);
        exp_q.delete();
        clearWindows();
        applyStimulus(REQ_COMMAND, 8'h3C);
        waitIdle();
        checkBurst("after_abort", 1, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
